// File: rtl/hazard_unit.sv
// Pipeline hazard control: Execute operand forwarding, load-use stalls, PC-write drain, stall counter.
// Forwarding and stall/flush outputs are combinational in the same cycle; the drain holds Fetch until W resolves.
module hazard_unit #(
  parameter int ADDR_W       = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [ADDR_W-1:0] RA1E,
  input  logic [ADDR_W-1:0] RA2E,
  input  logic [ADDR_W-1:0] WA3E,
  input  logic [ADDR_W-1:0] WA3M,
  input  logic [ADDR_W-1:0] WA3W,
  input  logic              MemtoRegE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcD,
  input  logic              PCSrcW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              Draining,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int                DCNT_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ADDR_W-1:0] PC_REG    = ADDR_W'(15);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               ldstall;

  // R15 is the PC: its value never comes from a later pipeline stage.
  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0] ra,
    input logic              wr_m,
    input logic [ADDR_W-1:0] wa_m,
    input logic              wr_w,
    input logic [ADDR_W-1:0] wa_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != PC_REG) begin
      if (wr_m && (wa_m == ra)) begin
        sel = 2'b10;
      end else if (wr_w && (wa_w == ra)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  assign ldstall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
      ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    if (rst) begin
      FlushD  = 1'b1;
      FlushE  = 1'b1;
      state_d = ST_RUN;
      dcnt_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // A stalled load-use consumer re-presents PCSrcD next cycle, so it wins.
          if (ldstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end else if (PCSrcD) begin
            StallF  = 1'b1;
            FlushD  = 1'b1;
            state_d = ST_DRAIN;
            dcnt_d  = DCNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (dcnt_q < DCNT_LAST) begin
            StallF = 1'b1;
            FlushD = 1'b1;
            dcnt_d = dcnt_q + DCNT_ONE;
          end else begin
            // Resolution: the held fall-through survives only on a not-taken PC write.
            FlushD  = PCSrcW;
            state_d = ST_RUN;
            dcnt_d  = '0;
          end
        end
        default: begin
          state_d = ST_RUN;
          dcnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign Draining   = (state_q == ST_DRAIN) && !rst;
  assign StallCount = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      dcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed bench for hazard_unit against a cycle-indexed reference model.
module tb_hazard_unit;

  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        MemtoRegE, RegWriteM, RegWriteW, PCSrcD, PCSrcW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE, Draining;
  logic [15:0] StallCount;

  logic [1:0]  fa4, fb4;
  logic        sf4, sd4, fd4, fe4, dr4;
  logic [3:0]  StallCount4;

  always #5 clk = ~clk;

  hazard_unit #(.ADDR_W(4), .DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcD(PCSrcD), .PCSrcW(PCSrcW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .Draining(Draining), .StallCount(StallCount)
  );

  hazard_unit #(.ADDR_W(4), .DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcD(PCSrcD), .PCSrcW(PCSrcW),
    .ForwardAE(fa4), .ForwardBE(fb4),
    .StallF(sf4), .StallD(sd4), .FlushD(fd4), .FlushE(fe4),
    .Draining(dr4), .StallCount(StallCount4)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: a drain is remembered by the cycle index it was accepted in.
  bit   in_drain;
  int   drain_start, cyc, scnt, scnt4;
  logic [1:0] e_fa, e_fb;
  logic e_sf, e_sd, e_fd, e_fe, e_dr;

  logic [1:0]  s_fa, s_fb;
  logic        s_sf, s_sd, s_fd, s_fe, s_dr;
  logic [15:0] s_cnt;
  logic [3:0]  s_cnt4;

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_ld();
    return MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
  endfunction

  task automatic model_eval();
    e_fa = 2'b00; e_fb = 2'b00;
    e_sf = 0; e_sd = 0; e_fd = 0; e_fe = 0; e_dr = 0;
    if (rst) begin
      e_fd = 1; e_fe = 1;
    end else begin
      e_fa = ref_fwd(RA1E);
      e_fb = ref_fwd(RA2E);
      e_dr = in_drain;
      if (in_drain) begin
        if (cyc - drain_start < DRAIN) begin
          e_sf = 1; e_fd = 1;
        end else begin
          e_fd = PCSrcW;
        end
      end else if (ref_ld()) begin
        e_sf = 1; e_sd = 1; e_fe = 1;
      end else if (PCSrcD) begin
        e_sf = 1; e_fd = 1;
      end
    end
  endtask

  task automatic model_step();
    if (rst) begin
      in_drain = 0; scnt = 0; scnt4 = 0;
    end else begin
      if (e_sf) begin
        scnt  = (scnt  < 65535) ? scnt + 1  : scnt;
        scnt4 = (scnt4 < 15)    ? scnt4 + 1 : scnt4;
      end
      if (in_drain) begin
        if (cyc - drain_start >= DRAIN) in_drain = 0;
      end else if (!ref_ld() && PCSrcD) begin
        in_drain = 1;
        drain_start = cyc;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    s_fa = ForwardAE; s_fb = ForwardBE; s_sf = StallF; s_sd = StallD;
    s_fd = FlushD; s_fe = FlushE; s_dr = Draining; s_cnt = StallCount; s_cnt4 = StallCount4;
    check_eq("ForwardAE", 32'(s_fa), 32'(e_fa));
    check_eq("ForwardBE", 32'(s_fb), 32'(e_fb));
    check_eq("StallF", 32'(s_sf), 32'(e_sf));
    check_eq("StallD", 32'(s_sd), 32'(e_sd));
    check_eq("FlushD", 32'(s_fd), 32'(e_fd));
    check_eq("FlushE", 32'(s_fe), 32'(e_fe));
    check_eq("Draining", 32'(s_dr), 32'(e_dr));
    check_eq("StallCount", 32'(s_cnt), 32'(scnt));
    check_eq("StallCount4", 32'(s_cnt4), 32'(scnt4));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0;
    WA3E = 4'd9; WA3M = 0; WA3W = 0;
    MemtoRegE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcD = 0; PCSrcW = 0;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  task automatic run_drain(input logic taken, input int base_cnt);
    PCSrcD = 1; cycle();
    check_eq("drain_c1_stallf", 32'(s_sf), 32'd1);
    check_eq("drain_c1_flushd", 32'(s_fd), 32'd1);
    PCSrcD = 0;
    for (int i = 2; i <= 3; i++) begin
      cycle();
      check_eq("drain_mid_stallf", 32'(s_sf), 32'd1);
      check_eq("drain_mid_flushd", 32'(s_fd), 32'd1);
      check_eq("drain_mid_draining", 32'(s_dr), 32'd1);
    end
    PCSrcW = taken; cycle();
    check_eq("drain_c4_stallf", 32'(s_sf), 32'd0);
    check_eq("drain_c4_flushd", 32'(s_fd), 32'(taken));
    check_eq("drain_c4_draining", 32'(s_dr), 32'd1);
    PCSrcW = 0; cycle();
    check_eq("drain_after_draining", 32'(s_dr), 32'd0);
    check_eq("drain_count", 32'(s_cnt), 32'(base_cnt + 3));
  endtask

  initial begin
    in_drain = 0; drain_start = 0; cyc = 0; scnt = 0; scnt4 = 0;
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    cycle();
    check_eq("rst_flushd", 32'(s_fd), 32'd1);
    check_eq("rst_flushe", 32'(s_fe), 32'd1);
    check_eq("rst_stallf", 32'(s_sf), 32'd0);
    rst = 0;

    // Load-use on RA2D
    MemtoRegE = 1; WA3E = 4'd2; RA2D = 4'd2; cycle();
    check_eq("lu_stallf", 32'(s_sf), 32'd1);
    check_eq("lu_stalld", 32'(s_sd), 32'd1);
    check_eq("lu_flushe", 32'(s_fe), 32'd1);
    check_eq("lu_cnt_before", 32'(s_cnt), 32'd0);
    clear_inputs(); cycle();
    check_eq("lu_released", 32'(s_sf), 32'd0);
    check_eq("lu_cnt_after", 32'(s_cnt), 32'd1);

    // Forwarding priority
    RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 5; cycle();
    check_eq("fwd_m_prio", 32'(s_fa), 32'd2);
    check_eq("fwd_b_none", 32'(s_fb), 32'd0);
    RegWriteM = 0; cycle();
    check_eq("fwd_w", 32'(s_fa), 32'd1);
    RA1E = 15; WA3W = 15; cycle();
    check_eq("fwd_r15", 32'(s_fa), 32'd0);
    clear_inputs();

    run_drain(1'b1, 1);
    run_drain(1'b0, 4);

    // ldstall and PCSrcD together: stall wins, drain follows
    MemtoRegE = 1; WA3E = 4'd2; RA1D = 4'd2; PCSrcD = 1; cycle();
    check_eq("both_stalld", 32'(s_sd), 32'd1);
    check_eq("both_flushd", 32'(s_fd), 32'd0);
    MemtoRegE = 0; cycle();
    check_eq("both_then_flushd", 32'(s_fd), 32'd1);
    PCSrcD = 0; cycle();
    check_eq("both_then_drain", 32'(s_dr), 32'd1);

    // Reset while dcnt==2
    rst = 1; cycle();
    check_eq("rstmid_flushd", 32'(s_fd), 32'd1);
    check_eq("rstmid_flushe", 32'(s_fe), 32'd1);
    check_eq("rstmid_stallf", 32'(s_sf), 32'd0);
    rst = 0; clear_inputs(); cycle();
    check_eq("rstmid_draining", 32'(s_dr), 32'd0);
    check_eq("rstmid_cnt", 32'(s_cnt), 32'd0);

    // Saturation on the narrow counter
    MemtoRegE = 1; WA3E = 4'd2; RA1D = 4'd2;
    for (int i = 0; i < 20; i++) cycle();
    clear_inputs(); cycle();
    check_eq("sat_cnt4", 32'(s_cnt4), 32'd15);
    check_eq("sat_cnt16", 32'(s_cnt), 32'd20);

    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      RA1D      = rnd_reg(); RA2D = rnd_reg();
      RA1E      = rnd_reg(); RA2E = rnd_reg();
      WA3E      = rnd_reg(); WA3M = rnd_reg(); WA3W = rnd_reg();
      MemtoRegE = ($urandom_range(0, 3) == 0);
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      PCSrcD    = ($urandom_range(0, 5) == 0);
      PCSrcW    = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumes the MEM/WB register outputs (RegWriteW, WA3W, PCSrcW) together with the E/M-stage write info, and returns control to the front of the pipeline.
- Produces:
  - operand forwarding selects for the Execute stage
  - load-use stalls
  - the PC-write drain sequence, which holds Fetch until a PC-writing instruction resolves in Writeback
  - a saturating stall-cycle counter for performance monitoring

Parameters:
- ADDR_W, 4, register address width.
- DRAIN_CYCLES, 3, number of cycles from drain entry to the Writeback resolution cycle (D→E→M→W).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- RA1D, RA2D  in  ADDR_W  source registers of the instruction in Decode.
- RA1E, RA2E  in  ADDR_W  source registers of the instruction in Execute.
- WA3E, WA3M, WA3W  in  ADDR_W  destination registers in E, M, W.
- MemtoRegE  in  1  instruction in E is a load.
- RegWriteM, RegWriteW  in  1  register-write enables in M, W.
- PCSrcD  in  1  instruction in D writes the PC.
- PCSrcW  in  1  PC write is taken in W (condition already applied).
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = Writeback result, 10 = ALUOutM.
- StallF, StallD  out  1  hold PC / hold the F/D register.
- FlushD, FlushE  out  1  clear the F/D register / clear the D/E register.
- Draining  out  1  FSM in DRAIN.
- StallCount  out  CNT_W  cycles with StallF=1 since reset.

Behaviour:
- Forwarding (combinational, evaluated for A and B independently, operand A shown):
  - 10 if RegWriteM && WA3M==RA1E && RA1E!=15.
  - Otherwise 01 if RegWriteW && WA3W==RA1E && RA1E!=15.
  - Otherwise 00.
  - M has priority over W when both match.
  - R15 is never forwarded.
- Load-use detect: ldstall = MemtoRegE && (WA3E==RA1D || WA3E==RA2D). This is evaluated only in RUN.
- FSM states: RUN, DRAIN. There is a counter dcnt of width clog2(DRAIN_CYCLES+1).
- RUN, ldstall=1:
  - StallF=1, StallD=1, FlushE=1.
  - Stay in RUN.
  - ldstall has priority over PCSrcD; the stalled instruction re-presents PCSrcD on the next cycle.
- RUN, ldstall=0 and PCSrcD=1:
  - Outputs this cycle: StallF=1, FlushD=1.
  - Next state DRAIN, dcnt←1.
- RUN, neither condition:
  - All stall and flush outputs are 0.
- DRAIN, dcnt<DRAIN_CYCLES:
  - StallF=1, FlushD=1, StallD=0, FlushE=0.
  - dcnt←dcnt+1.
- DRAIN, dcnt==DRAIN_CYCLES (resolution cycle, in which the PC-writing instruction is in W):
  - StallF=0, so the PC loads the target if PCSrcW=1, else PC+4.
  - FlushD=PCSrcW, so the held fall-through instruction is squashed only if the branch is taken.
  - Next state RUN, dcnt←0.
- ldstall and PCSrcD are ignored in DRAIN. D is flushed, so no new hazard can originate there.
- Draining=1 exactly while state==DRAIN.
- StallCount increments each cycle StallF=1 and saturates at all-ones; it does not wrap.
- While rst=1, outputs are:
  - StallF=0, StallD=0, FlushD=1, FlushE=1
  - ForwardAE=ForwardBE=00, Draining=0
- On the rst edge: state←RUN, dcnt←0, StallCount←0.
- Reset mid-drain aborts the drain immediately. The first cycle after rst deasserts is in RUN.
- No output depends on rst asynchronously.

Test Plan:
- Forwarding priority:
  - Stimulus: RegWriteM=1, WA3M=3; RegWriteW=1, WA3W=3; RA1E=3; RA2E=5.
  - Required: ForwardAE=10, ForwardBE=00.
  - Then drop RegWriteM: ForwardAE=01.
  - Then set RA1E=15 with WA3W=15: ForwardAE=00.
- Load-use:
  - Stimulus: MemtoRegE=1, WA3E=2, RA2D=2 for one cycle.
  - Required: StallF=StallD=FlushE=1 for exactly that cycle; StallCount goes 0→1.
- Taken PC write:
  - Stimulus: PCSrcD=1 for 1 cycle, then PCSrcW=1 on the 4th cycle.
  - Required:
    - StallF=1, FlushD=1 on cycles 1–3.
    - Cycle 4: StallF=0, FlushD=1.
    - Draining=1 on cycles 2–4.
    - StallCount=3.
- Untaken PC write: same as the taken case with PCSrcW=0 on cycle 4. Required: cycle 4 has StallF=0, FlushD=0.
- Simultaneous ldstall and PCSrcD in RUN:
  - Required: load-use stall only (no DRAIN entry).
  - Next cycle with ldstall=0 and PCSrcD=1: enter DRAIN.
- Reset mid-drain and saturation:
  - Reset mid-drain: assert rst at dcnt=2. Required: FlushD=FlushE=1, StallF=0; after release, Draining=0 and StallCount=0.
  - Saturation: with CNT_W=4, hold ldstall for 20 cycles. Required: StallCount stays at 15.
